// File: rtl/psum_accum_layer3_pkg.sv
// Shared layer-3 partial-sum accumulation definitions: sizes, FSM state and element type.
package psum_accum_layer3_pkg;

  localparam int MACRO_NUM = 4;
  localparam int OUT_CH    = 64;
  localparam int PHASE_NUM = 4;
  localparam int ACC_W     = 8;
  localparam int IN_W      = 4;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic signed [ACC_W-1:0] psum_t;

  // Widen a signed 4-bit macro result to accumulator width.
  function automatic psum_t sext_in(input logic [IN_W-1:0] v);
    return {{(ACC_W-IN_W){v[IN_W-1]}}, v};
  endfunction

endpackage

// File: rtl/psum_accum_layer3_lane.sv
// One output channel: adds two macro results and accumulates them across phases.
module psum_lane
  import psum_accum_layer3_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            beat,
  input  logic            first,
  input  logic            last,
  input  logic [IN_W-1:0] a,
  input  logic [IN_W-1:0] b,
  output psum_t           result
);

  psum_t acc;
  psum_t pair_sum;
  psum_t next_sum;

  assign pair_sum = sext_in(a) + sext_in(b);
  assign next_sum = first ? pair_sum : acc + pair_sum;

  // Running sum restarts on phase 0; the last phase publishes the total to the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      result <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (beat) begin
      acc <= next_sum;
      if (last) begin
        result <= next_sum;
      end
    end
  end

endmodule

// File: rtl/psum_accum_layer3.sv
// Layer-3 partial-sum accumulator: phase counter, output handshake and 128 channel lanes.
module psum_accum_layer3 #(
  parameter int MACRO_NUM = psum_accum_layer3_pkg::MACRO_NUM,
  parameter int OUT_CH    = psum_accum_layer3_pkg::OUT_CH,
  parameter int PHASE_NUM = psum_accum_layer3_pkg::PHASE_NUM,
  parameter int ACC_W     = psum_accum_layer3_pkg::ACC_W
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   clear,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [MACRO_NUM-1:0][OUT_CH-1:0][psum_accum_layer3_pkg::IN_W-1:0] data_in,
  output logic [1:0]                                             chs_ps,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [2*OUT_CH-1:0][ACC_W-1:0]                         data_out
);

  import psum_accum_layer3_pkg::state_t;
  import psum_accum_layer3_pkg::ACC;
  import psum_accum_layer3_pkg::HOLD;

  localparam logic [1:0] LAST_PH = 2'(PHASE_NUM - 1);

  state_t     state;
  logic [1:0] phase;
  logic       last_ph;
  logic       beat;
  logic       complete;

  assign last_ph  = (phase == LAST_PH);
  assign in_ready = !(last_ph && out_valid && !out_ready);
  assign beat     = in_valid && in_ready && !clear;
  assign complete = beat && last_ph;
  assign chs_ps   = phase;

  // Phase stepping plus the ACC/HOLD output state; a drain and a completion in one cycle stay in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      out_valid <= 1'b0;
      phase     <= '0;
    end else begin
      if (clear) begin
        phase <= '0;
      end else if (beat) begin
        phase <= last_ph ? 2'd0 : phase + 2'd1;
      end
      case (state)
        ACC: begin
          if (complete) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready && !complete) begin
            state     <= ACC;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  for (genvar c = 0; c < OUT_CH; c++) begin : g_lane
    psum_lane u_lo (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .beat   (beat),
      .first  (phase == 2'd0),
      .last   (last_ph),
      .a      (data_in[0][c]),
      .b      (data_in[1][c]),
      .result (data_out[c])
    );
    psum_lane u_hi (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .beat   (beat),
      .first  (phase == 2'd0),
      .last   (last_ph),
      .a      (data_in[2][c]),
      .b      (data_in[3][c]),
      .result (data_out[c+OUT_CH])
    );
  end

endmodule
